// File: rtl/mesh_term_injector.sv
// mesh_term_injector
//   Terminal-side injection buffer for one external port of the mesh. Packets
//   from the test agent are target-checked, stamped with this terminal's source
//   id and queued in a circular FIFO whose head is presented to the edge router.
//   Accepted/dropped/rejected/delivered activity is counted for the scoreboard.
//
//   Handshake: an entry is offered while pndng=1 with data_out holding it; the
//   router consumes it by raising pop for a clock edge (one entry per edge).
//   A push is a single-cycle strobe sampled on the rising edge; an accepted push
//   becomes visible on pndng/data_out one cycle later.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   push, data_in     agent write strobe and packet
//   full, count       FIFO full flag and occupancy
//   pndng, data_out   head valid and head packet (all-zero when empty)
//   pop               router consume strobe
//   overflow          sticky: a push was dropped while full
//   underflow         sticky: pop seen while empty
//   drop_cnt          pushes dropped because full (saturating)
//   bad_cnt           pushes rejected for an invalid target (saturating)
//   tx_cnt            packets popped by the router (wrapping)
module mesh_term_injector #(
  parameter int          PCKG_SZ = 40,
  parameter int          DEPTH   = 4,
  parameter int          ROWS    = 4,
  parameter int          COLUMS  = 4,
  parameter int          SRC_ROW = 0,
  parameter int          SRC_COL = 0,
  parameter logic [7:0]  BDCST   = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [PCKG_SZ-1:0]       data_in,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pndng,
  output logic [PCKG_SZ-1:0]       data_out,
  input  logic                     pop,
  output logic                     overflow,
  output logic                     underflow,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              bad_cnt,
  output logic [15:0]              tx_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
  localparam logic [5:0]    ROWS_L  = 6'(ROWS);
  localparam logic [5:0]    COLS_L  = 6'(COLUMS);
  localparam logic [7:0]    SRC_ID  = {4'(SRC_ROW), 4'(SRC_COL)};

  logic [PCKG_SZ-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  logic [7:0]         target;
  logic               tgt_ok;
  logic               empty;
  logic               pop_ok;
  logic               push_ok;
  logic               push_drop;
  logic               push_bad;
  logic [PCKG_SZ-1:0] stamped;

  assign target = data_in[PCKG_SZ-1 -: 8];
  assign tgt_ok = (({2'b00, target[7:4]} < ROWS_L) && ({2'b00, target[3:0]} < COLS_L))
                  || (target == BDCST);

  assign empty = (count == '0);
  assign full  = (count == DEPTH_L);

  // A pop on an empty FIFO never pairs with a push: the push lands in the
  // empty slot and the pop only raises underflow.
  assign pop_ok    = pop && !empty;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_ok   = push && tgt_ok && (!full || pop_ok);
  assign push_drop = push && tgt_ok && full && !pop_ok;
  // Rejection happens regardless of occupancy.
  assign push_bad  = push && !tgt_ok;

  always_comb begin
    stamped = data_in;
    stamped[PCKG_SZ-10 -: 8] = SRC_ID;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
      bad_cnt   <= '0;
      tx_cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        tx_cnt <= tx_cnt + 16'd1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (push_bad && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
      if (pop && empty) underflow <= 1'b1;
    end
  end

  // Storage is not reset; stale entries are masked by pndng below.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= stamped;
  end

  assign pndng    = !empty;
  assign data_out = pndng ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mesh_term_injector.sv
module tb_mesh_term_injector;

  localparam int P = 40;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [P-1:0]  data_in;
  logic          full;
  logic [2:0]    count;
  logic          pndng;
  logic [P-1:0]  data_out;
  logic          pop;
  logic          overflow;
  logic          underflow;
  logic [15:0]   drop_cnt;
  logic [15:0]   bad_cnt;
  logic [15:0]   tx_cnt;

  always #5 clk = ~clk;

  mesh_term_injector #(
    .PCKG_SZ(P), .DEPTH(4), .ROWS(4), .COLUMS(4),
    .SRC_ROW(0), .SRC_COL(0), .BDCST(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in),
    .full(full), .count(count), .pndng(pndng), .data_out(data_out),
    .pop(pop), .overflow(overflow), .underflow(underflow),
    .drop_cnt(drop_cnt), .bad_cnt(bad_cnt), .tx_cnt(tx_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [P-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet layout: target[39:32] mode[31] src[30:23] payload[22:0]
  function automatic logic [P-1:0] mk(input logic [7:0] tgt, input logic mode,
                                      input logic [7:0] src, input logic [22:0] pl);
    return {tgt, mode, src, pl};
  endfunction

  // Monitor: inputs change #1 after posedge, so at negedge they are stable for
  // the coming edge; a pop with pndng high consumes the current head.
  always @(negedge clk) begin
    if (!rst && pop && pndng) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_head: got %0h with empty expected queue", data_out);
      end else begin
        chk("pop_head", 64'(data_out), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic p, input logic [P-1:0] d, input logic q);
    push = p; data_in = d; pop = q;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; data_in = '0;
  endtask

  // Push a packet with a junk source field; the expected copy carries src=00.
  task automatic push_ok_pkt(input logic [7:0] tgt, input logic mode, input logic [22:0] pl);
    exp_q.push_back(mk(tgt, mode, 8'h00, pl));
    step(1'b1, mk(tgt, mode, 8'hA5, pl), 1'b0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // reset state
    chk("rst_pndng", 64'(pndng), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_cnts", {16'd0, drop_cnt, bad_cnt, tx_cnt}, 64'd0);

    // T1 fill/drain
    for (int i = 1; i <= 4; i++) push_ok_pkt(8'h12, 1'(i), 23'(i));
    chk("t1_full", 64'(full), 64'd1);
    chk("t1_count", 64'(count), 64'd4);
    chk("t1_head", 64'(data_out), 64'(mk(8'h12, 1'b1, 8'h00, 23'd1)));
    repeat (4) step(1'b0, '0, 1'b1);
    chk("t1_tx", 64'(tx_cnt), 64'd4);
    chk("t1_pndng", 64'(pndng), 64'd0);
    chk("t1_data_zero", 64'(data_out), 64'd0);

    // T2 overflow
    for (int i = 5; i <= 8; i++) push_ok_pkt(8'h33, 1'b0, 23'(i));
    step(1'b1, mk(8'h12, 1'b0, 8'h00, 23'd9), 1'b0);
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_head", 64'(data_out), 64'(mk(8'h33, 1'b0, 8'h00, 23'd5)));

    // T3 simultaneous push+pop while full
    exp_q.push_back(mk(8'h21, 1'b1, 8'h00, 23'h10));
    step(1'b1, mk(8'h21, 1'b1, 8'h5A, 23'h10), 1'b1);
    chk("t3_full_count", 64'(count), 64'd4);
    chk("t3_full_drop", 64'(drop_cnt), 64'd1);
    chk("t3_udf_before", 64'(underflow), 64'd0);
    repeat (4) step(1'b0, '0, 1'b1);
    // push+pop while empty
    exp_q.push_back(mk(8'h00, 1'b0, 8'h00, 23'h11));
    step(1'b1, mk(8'h00, 1'b0, 8'hFF, 23'h11), 1'b1);
    chk("t3_empty_count", 64'(count), 64'd1);
    chk("t3_udf", 64'(underflow), 64'd1);
    chk("t3_tx", 64'(tx_cnt), 64'd9);
    step(1'b0, '0, 1'b1);

    // T4 validation
    step(1'b1, mk(8'h44, 1'b0, 8'h00, 23'h40), 1'b0);
    step(1'b1, mk(8'h05, 1'b0, 8'h00, 23'h41), 1'b0);
    push_ok_pkt(8'hFF, 1'b1, 23'h42);
    chk("t4_bad", 64'(bad_cnt), 64'd2);
    chk("t4_count", 64'(count), 64'd1);
    step(1'b0, '0, 1'b1);
    chk("t4_tx", 64'(tx_cnt), 64'd11);

    // T5 wrap: 10 push/pop pairs move the pointers around the ring twice
    for (int i = 0; i < 10; i++) begin
      push_ok_pkt(8'h30 + 8'(i % 4), 1'(i), 23'h20 + 23'(i));
      step(1'b0, '0, 1'b1);
    end
    chk("t5_tx", 64'(tx_cnt), 64'd21);
    chk("t5_count", 64'(count), 64'd0);

    // invalid target while full is still rejected, not dropped
    for (int i = 0; i < 4; i++) push_ok_pkt(8'h03, 1'b0, 23'h50 + 23'(i));
    step(1'b1, mk(8'h50, 1'b0, 8'h00, 23'h5F), 1'b0);
    chk("full_bad", 64'(bad_cnt), 64'd3);
    chk("full_bad_drop", 64'(drop_cnt), 64'd1);

    // T6 reset mid-traffic: count=3 with pop held, reset lands mid-cycle
    step(1'b0, '0, 1'b1);
    chk("t6_count3", 64'(count), 64'd3);
    pop = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_pndng", 64'(pndng), 64'd0);
    chk("t6_data", 64'(data_out), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_cnts", {13'd0, overflow, underflow, full, drop_cnt, bad_cnt, tx_cnt}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    pop = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    // push is registered: not visible before the edge
    exp_q.push_back(mk(8'h11, 1'b1, 8'h00, 23'h77));
    push = 1'b1; data_in = mk(8'h11, 1'b1, 8'hC3, 23'h77);
    #1 chk("t6_no_comb", 64'(pndng), 64'd0);
    @(posedge clk); #1;
    push = 1'b0; data_in = '0;
    chk("t6_pndng_after", 64'(pndng), 64'd1);
    chk("t6_data_after", 64'(data_out), 64'(mk(8'h11, 1'b1, 8'h00, 23'h77)));
    step(1'b0, '0, 1'b1);
    chk("t6_tx", 64'(tx_cnt), 64'd1);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
